// File: rtl/nqueen_solver.sv
// N-Queens backtracking solver: one-hot row registers, pairwise safety check,
// streams every solution row-by-row over a valid/ready port.
module nqueen_solver #(
  parameter int N  = 8,
  parameter int RW = (N > 1 ? $clog2(N) : 1),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          next,
  output logic [N-1:0]  out_data,
  output logic [RW-1:0] out_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          found,
  output logic          exhausted,
  output logic [CW-1:0] sol_count
);

  localparam logic [N-1:0]  TOP  = N'(1) << (N - 1);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, ACCEPT, SHIFT, STREAM, WAIT, EXH
  } state_t;

  state_t state, nstate;

  logic [N-1:0]  rows [N];
  logic [RW-1:0] r, k, i;
  logic [RW-1:0] cr, ck;
  logic [RW:0]   dr, dc;
  logic          unsafe;
  logic          load;

  function automatic logic [RW-1:0] col_of(input logic [N-1:0] v);
    col_of = '0;
    for (int b = 0; b < N; b++)
      if (v[b]) col_of = RW'(b);
  endfunction

  always_comb begin
    cr = col_of(rows[r]);
    ck = col_of(rows[k]);
    dr = {1'b0, r} - {1'b0, k};
    dc = (cr >= ck) ? {1'b0, cr} - {1'b0, ck}
                    : {1'b0, ck} - {1'b0, cr};
    unsafe = (cr == ck) || (dr == dc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    load      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    out_row   = '0;
    busy      = 1'b1;
    found     = 1'b0;
    exhausted = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load   = 1'b1;
          nstate = ACCEPT;
        end
      end
      CHECK: begin
        if (unsafe)       nstate = SHIFT;
        else if (k == '0) nstate = ACCEPT;
      end
      ACCEPT: nstate = (r == LAST) ? STREAM : CHECK;
      SHIFT: begin
        if (rows[r][0]) begin
          if (r == '0) nstate = EXH;
        end else begin
          nstate = (r == '0) ? ACCEPT : CHECK;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = rows[i];
        out_row   = i;
        out_last  = (i == LAST);
        if (out_ready && i == LAST) nstate = WAIT;
      end
      WAIT: begin
        busy  = 1'b0;
        found = 1'b1;
        if (start) begin
          load   = 1'b1;
          nstate = ACCEPT;
        end else if (next) begin
          nstate = SHIFT;
        end
      end
      EXH: begin
        busy      = 1'b0;
        exhausted = 1'b1;
        if (start) begin
          load   = 1'b1;
          nstate = ACCEPT;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) rows[j] <= '0;
      r         <= '0;
      k         <= '0;
      i         <= '0;
      sol_count <= '0;
    end else if (load) begin
      for (int j = 0; j < N; j++) rows[j] <= '0;
      rows[0]   <= TOP;
      r         <= '0;
      sol_count <= '0;
    end else begin
      unique case (state)
        CHECK: begin
          if (!unsafe && k != '0) k <= k - RW'(1);
        end
        ACCEPT: begin
          if (r == LAST) begin
            i <= '0;
            if (sol_count != '1) sol_count <= sol_count + CW'(1);
          end else begin
            r                <= r + RW'(1);
            rows[r + RW'(1)] <= TOP;
            k                <= r;
          end
        end
        SHIFT: begin
          // exhausted column: clear row and backtrack one row up
          if (rows[r][0]) begin
            rows[r] <= '0;
            if (r != '0) r <= r - RW'(1);
          end else begin
            rows[r] <= rows[r] >> 1;
            if (r != '0) k <= r - RW'(1);
          end
        end
        STREAM: begin
          if (out_ready && i != LAST) i <= i + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nqueen_solver.sv
// Directed bench for nqueen_solver: instances for N=4, 8, 3, 1 share clock,
// reset and out_ready; each test task drives one instance and checks inline.
module tb_nqueen_solver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic [3:0] start_v = '0;
  logic [3:0] next_v = '0;
  logic [3:0] vld, lst, bsy, fnd, exh;
  logic [15:0] cnt [4];

  logic [3:0] d4_data;
  logic [1:0] d4_row;
  logic [7:0] d8_data;
  logic [2:0] d8_row;
  logic [2:0] d3_data;
  logic [1:0] d3_row;
  logic [0:0] d1_data;
  logic [0:0] d1_row;

  int errors = 0;
  int checks = 0;

  int sel = 0;
  logic [15:0] m_data;
  logic [3:0]  m_row;
  logic m_valid, m_last, m_exh, m_found, m_busy;
  logic [15:0] m_cnt;

  logic [15:0] bd [16];
  logic [3:0]  br [16];
  logic        bl [16];
  int beats, unstable;
  bit tmo;

  always #5 clk = ~clk;

  nqueen_solver #(.N(4)) d4 (
    .clk(clk), .reset(rst_n), .start(start_v[0]), .next(next_v[0]),
    .out_data(d4_data), .out_row(d4_row), .out_valid(vld[0]),
    .out_ready(rdy), .out_last(lst[0]), .busy(bsy[0]), .found(fnd[0]),
    .exhausted(exh[0]), .sol_count(cnt[0]));

  nqueen_solver #(.N(8)) d8 (
    .clk(clk), .reset(rst_n), .start(start_v[1]), .next(next_v[1]),
    .out_data(d8_data), .out_row(d8_row), .out_valid(vld[1]),
    .out_ready(rdy), .out_last(lst[1]), .busy(bsy[1]), .found(fnd[1]),
    .exhausted(exh[1]), .sol_count(cnt[1]));

  nqueen_solver #(.N(3)) d3 (
    .clk(clk), .reset(rst_n), .start(start_v[2]), .next(next_v[2]),
    .out_data(d3_data), .out_row(d3_row), .out_valid(vld[2]),
    .out_ready(rdy), .out_last(lst[2]), .busy(bsy[2]), .found(fnd[2]),
    .exhausted(exh[2]), .sol_count(cnt[2]));

  nqueen_solver #(.N(1)) d1 (
    .clk(clk), .reset(rst_n), .start(start_v[3]), .next(next_v[3]),
    .out_data(d1_data), .out_row(d1_row), .out_valid(vld[3]),
    .out_ready(rdy), .out_last(lst[3]), .busy(bsy[3]), .found(fnd[3]),
    .exhausted(exh[3]), .sol_count(cnt[3]));

  always_comb begin
    m_data = '0;
    m_row  = '0;
    case (sel)
      0: begin m_data = 16'(d4_data); m_row = 4'(d4_row); end
      1: begin m_data = 16'(d8_data); m_row = 4'(d8_row); end
      2: begin m_data = 16'(d3_data); m_row = 4'(d3_row); end
      default: begin m_data = 16'(d1_data); m_row = 4'(d1_row); end
    endcase
    m_valid = vld[sel];
    m_last  = lst[sel];
    m_exh   = exh[sel];
    m_found = fnd[sel];
    m_busy  = bsy[sel];
    m_cnt   = cnt[sel];
  end

  task automatic pulse(input int s, input bit st, input bit nx);
    start_v[s] = st;
    next_v[s]  = nx;
    @(negedge clk);
    start_v[s] = 1'b0;
    next_v[s]  = 1'b0;
  endtask

  // Gathers one streamed board from instance sel; stops early on exhaustion.
  task automatic collect(input int s, input bit rnd, input bit poke);
    logic held;
    logic done;
    logic [15:0] pd;
    logic [3:0] pr;
    held = 0; done = 0; pd = '0; pr = '0;
    beats = 0; unstable = 0; tmo = 1;
    for (int c = 0; c < 20000; c++) begin
      if (held && (!m_valid || m_data !== pd || m_row !== pr))
        unstable++;
      held = 0;
      if (m_exh) begin tmo = 0; break; end
      start_v[s] = poke && beats == 3;
      next_v[s]  = poke && beats == 3;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && rdy) begin
        if (beats < 16) begin
          bd[beats] = m_data;
          br[beats] = m_row;
          bl[beats] = m_last;
        end
        beats++;
        done = m_last;
      end else if (m_valid) begin
        held = 1; pd = m_data; pr = m_row;
      end
      @(negedge clk);
      if (done) begin tmo = 0; break; end
    end
    start_v[s] = 1'b0;
    next_v[s]  = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({vld, lst, bsy, fnd, exh} !== 20'h0) begin
      errors++;
      $display("FAIL reset_flags got %h want 0", {vld, lst, bsy, fnd, exh});
    end
    checks++;
    if ({cnt[0], cnt[1], cnt[2], cnt[3]} !== 64'h0) begin
      errors++;
      $display("FAIL reset_count got %h want 0", {cnt[0], cnt[1]});
    end
    checks++;
    if ({d4_data, d8_data, d4_row, d8_row} !== 17'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {d4_data, d8_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_board4(input string nm, input logic [15:0] e [4],
                              input logic [15:0] ec);
    checks++;
    if (tmo || beats !== 4) begin
      errors++;
      $display("FAIL %s_beats got %0d (tmo=%0d) want 4", nm, beats, tmo);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bd[j] !== e[j] || br[j] !== 4'(j) || bl[j] !== (j == 3)) begin
        errors++;
        $display("FAIL %s_row%0d got d=%h r=%0d l=%b want d=%h r=%0d l=%b",
                 nm, j, bd[j], br[j], bl[j], e[j], j, j == 3);
      end
    end
    checks++;
    if (m_cnt !== ec || m_found !== 1'b1 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status got cnt=%0d found=%b busy=%b want %0d 1 0",
               nm, m_cnt, m_found, m_busy, ec);
    end
  endtask

  task automatic test_n4_first();
    logic [15:0] e [4];
    e = '{16'h4, 16'h1, 16'h8, 16'h2};
    sel = 0;
    pulse(0, 1, 0);
    collect(0, 0, 0);
    check_board4("n4_first", e, 16'd1);
  endtask

  task automatic test_start_wins();
    logic [15:0] e [4];
    e = '{16'h4, 16'h1, 16'h8, 16'h2};
    sel = 0;
    pulse(0, 1, 1);
    collect(0, 0, 0);
    check_board4("start_wins", e, 16'd1);
  endtask

  task automatic test_n4_next();
    logic [15:0] e [4];
    e = '{16'h2, 16'h8, 16'h1, 16'h4};
    sel = 0;
    pulse(0, 0, 1);
    collect(0, 0, 0);
    check_board4("n4_second", e, 16'd2);
    pulse(0, 0, 1);
    collect(0, 0, 0);
    checks++;
    if (tmo || beats !== 0 || m_exh !== 1'b1 || m_cnt !== 16'd2) begin
      errors++;
      $display("FAIL n4_exhaust got exh=%b cnt=%0d beats=%0d want 1 2 0",
               m_exh, m_cnt, beats);
    end
    pulse(0, 0, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (m_exh !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL n4_next_ignored got exh=%b busy=%b want 1 0",
               m_exh, m_busy);
    end
  endtask

  task automatic test_n8_stall_and_count();
    logic [15:0] e [8];
    int boards;
    e = '{16'h80, 16'h08, 16'h01, 16'h04, 16'h20, 16'h02, 16'h40, 16'h10};
    sel = 1;
    pulse(1, 1, 0);
    collect(1, 1, 1);
    checks++;
    if (tmo || beats !== 8 || unstable !== 0) begin
      errors++;
      $display("FAIL n8_stall got beats=%0d unstable=%0d want 8 0",
               beats, unstable);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (bd[j] !== e[j] || br[j] !== 4'(j) || bl[j] !== (j == 7)) begin
        errors++;
        $display("FAIL n8_row%0d got d=%h r=%0d l=%b want d=%h r=%0d",
                 j, bd[j], br[j], bl[j], e[j], j);
      end
    end
    checks++;
    if (m_cnt !== 16'd1 || m_found !== 1'b1) begin
      errors++;
      $display("FAIL n8_first_status got cnt=%0d found=%b want 1 1",
               m_cnt, m_found);
    end
    boards = 1;
    for (int n = 0; n < 200; n++) begin
      pulse(1, 0, 1);
      collect(1, 0, 0);
      if (tmo || m_exh) break;
      if (beats == 8) boards++;
    end
    checks++;
    if (tmo || m_exh !== 1'b1 || boards !== 92 || m_cnt !== 16'd92) begin
      errors++;
      $display("FAIL n8_total got boards=%0d cnt=%0d exh=%b want 92 92 1",
               boards, m_cnt, m_exh);
    end
  endtask

  task automatic test_n3();
    sel = 2;
    pulse(2, 1, 0);
    collect(2, 0, 0);
    checks++;
    if (tmo || beats !== 0 || m_exh !== 1'b1 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL n3_exhaust got exh=%b cnt=%0d beats=%0d want 1 0 0",
               m_exh, m_cnt, beats);
    end
  endtask

  task automatic test_n1();
    sel = 3;
    pulse(3, 1, 0);
    collect(3, 0, 0);
    checks++;
    if (tmo || beats !== 1 || bd[0] !== 16'h1 || bl[0] !== 1'b1 ||
        br[0] !== 4'h0 || m_cnt !== 16'd1 || m_found !== 1'b1) begin
      errors++;
      $display("FAIL n1_board got beats=%0d d=%h l=%b cnt=%0d want 1 1 1 1",
               beats, bd[0], bl[0], m_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1;
    pulse(1, 1, 0);
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", m_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_check got busy=%b cnt=%0d want 0 0",
               m_busy, m_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b0;
    pulse(1, 1, 0);
    seen = 0;
    for (int c = 0; c < 5000; c++) begin
      if (m_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || m_valid !== 1'b0 || m_data !== 16'h0 || m_last !== 1'b0 ||
        m_found !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_stream got seen=%b v=%b d=%h cnt=%0d want 1 0 0 0",
               seen, m_valid, m_data, m_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_exh !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_after got v=%b busy=%b want 0 0",
               m_valid, m_busy);
    end
    rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_n4_first();
    test_start_wins();
    test_n4_next();
    test_n8_stall_and_count();
    test_n3();
    test_n1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
